mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage directly downstream of the PE controller. It accepts the controller's load/store request (`mem_read`/`mem_write`, `mem_address`, `funct3`) and runs a request/grant/response transaction on the PE's data-memory bus. It returns a one-cycle `mem_ack` with the sign- or zero-extended load value on `mem_Message`. Misaligned accesses and bus timeouts complete with an error flag instead of hanging the controller.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles spent in REQ+RESP before the transaction is abandoned (1..255).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request level from controller, held until `mem_ack`.
- `mem_write`  in  1  store request level, held until `mem_ack`.
- `mem_address`  in  32  byte address.
- `funct3`  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_wdata`  in  32  store data, low bits significant.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_Message`  out  32  extended load data; 0 for stores and errors.
- `mem_err`  out  1  valid with `mem_ack`: misaligned, illegal funct3, read+write together, or timeout.
- `bus_req`  out  1  bus request, held until `bus_gnt`.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, `{mem_address[31:2], 2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_gnt`  in  1  bus accepts the request in a cycle with `bus_req` high.
- `bus_rvalid`  in  1  response/write-done; `bus_rdata` valid.
- `bus_rdata`  in  32  read word.

## Operation
States: IDLE, REQ, RESP, ACK, HOLD.
- IDLE: exactly one of `mem_read`/`mem_write` high:
  - legal and aligned: latch address, funct3, `we`, and formatted wdata/`be` → REQ; timeout counter cleared.
  - illegal → ACK with `err`=1; no bus activity.
- Illegal means: both request lines high, undefined funct3 (loads: 011/110/111; stores: anything other than 000/001/010), H with `addr[0]`=1, or W with `addr[1:0]`≠0.
- REQ: `bus_req`=1 and bus outputs held stable. `bus_gnt` → RESP.
- RESP: `bus_rvalid` → capture extended data (loads) or 0 (stores) into `mem_Message` → ACK.
- Timeout: in REQ or RESP, counter reaching `TIMEOUT_CYCLES` → ACK with `err`=1 and `mem_Message`=0. A late `bus_rvalid` after that is ignored.
- ACK: `mem_ack`=1 for exactly one cycle → HOLD.
- HOLD: wait until `mem_read`=`mem_write`=0, then → IDLE. A held request is never reissued.
- Byte lanes, with `o`=`addr[1:0]`:
  - B: `be`=`4'b0001<<o`; H: `be`=`4'b0011<<o`; W: `be`=`4'b1111`.
  - Store data replicated: byte ×4, halfword ×2.
  - Load data = byte/half at lane `o`, sign-extended for B/H, zero-extended for BU/HU.
- `mem_Message` and `mem_err` are registered and hold their value until the next completion.
- `bus_rvalid` is ignored outside RESP. `bus_gnt` is ignored outside REQ.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE. All outputs 0: `mem_ack`, `mem_Message`, `mem_err`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`. Counter 0.
- Request sampled at edge 0 → `bus_req` high in cycle 1. With `gnt` in cycle 1 and `rvalid` in cycle 2, `mem_ack` is high in cycle 3. Minimum latency is 3 cycles.
- Error detected in IDLE → `mem_ack` in cycle 1.
- Back-to-back requests need at least one cycle with both request lines low after `mem_ack`.
- Reset asserted mid-transaction: immediate return to IDLE. `bus_req` drops and no `mem_ack` is produced.

## Structure
- Package `mem_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum.
- Sub-module `lsu_align`: combinational store formatting (`be`, replicated wdata), load extraction/extension, and misalignment detect. Instantiated once.
- The top level holds the FSM, timeout counter, and output registers.

## Test plan
- LB at 0x103, `bus_rdata`=0x80FF_1234; `gnt` cycle 1, `rvalid` cycle 2 → `bus_addr`=0x100, `be`=0001, `mem_ack` cycle 3, `mem_Message`=0xFFFF_FF80, `err`=0.
- LHU at 0x102, `rdata`=0xBEEF_0000 → `be`=1100, `mem_Message`=0x0000_BEEF.
- SB at 0x101, wdata=0x0000_00A5 → `bus_we`=1, `be`=0010, `bus_wdata`=0xA5A5_A5A5; `mem_Message`=0.
- LW at 0x002 → `mem_ack`+`err` at cycle 1, `bus_req` never asserted.
- `gnt` never asserted, `TIMEOUT_CYCLES`=8 → `mem_ack`+`err` after 8 REQ cycles. A subsequent `rvalid` is ignored.
- Request held 5 cycles past `mem_ack` → exactly one bus transaction. Reset pulled in RESP → all outputs 0 and no ack.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access stage.
//   - RV32I load/store size/sign encodings (funct3)
//   - FSM state encoding for mem_access_unit
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ACK,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: groups the controller-side request/ack signals and the
// data-memory bus signals of mem_access_unit.
//   master : the access unit (consumes controller requests, drives the bus)
//   slave  : the environment (controller + memory bus responder)
// Controller side: mem_read, mem_write, mem_address, funct3, mem_wdata,
//                  mem_ack, mem_Message, mem_err
// Bus side:        bus_req, bus_we, bus_addr, bus_be, bus_wdata,
//                  bus_gnt, bus_rvalid, bus_rdata
interface mem_access_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [2:0]  funct3;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_Message;
    logic        mem_err;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        input  mem_read, mem_write, mem_address, funct3, mem_wdata,
        output mem_ack, mem_Message, mem_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        output mem_read, mem_write, mem_address, funct3, mem_wdata,
        input  mem_ack, mem_Message, mem_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: purely combinational byte-lane logic for the access unit.
//   Store side (fed from the live request):
//     st_offset_i, st_funct3_i, st_we_i, st_wdata_i -> st_be_o, st_wdata_o,
//     st_illegal_o (undefined funct3 for the direction, or misaligned)
//   Load side (fed from the latched request):
//     ld_offset_i, ld_funct3_i, ld_rdata_i -> ld_data_o (extended value)
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_offset_i,
    input  logic [2:0]  st_funct3_i,
    input  logic        st_we_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        st_illegal_o,
    input  logic [1:0]  ld_offset_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [1:0]  st_size;
    logic        f3_bad;
    logic        misaligned;
    logic [31:0] ld_shifted;

    // funct3[1:0] encodes the access size (00 byte, 01 half, 10 word).
    assign st_size = st_funct3_i[1:0];

    // Size 11 never exists; bit 2 (unsigned) is only meaningful for B/H loads.
    assign f3_bad = (st_size == 2'b11) || (st_funct3_i[2] && (st_funct3_i[1] || st_we_i));

    always_comb begin
        st_be_o    = 4'b0000;
        misaligned = 1'b0;
        case (st_size)
            2'b00: st_be_o = 4'b0001 << st_offset_i;
            2'b01: begin
                st_be_o    = 4'b0011 << st_offset_i;
                misaligned = st_offset_i[0];
            end
            2'b10: begin
                st_be_o    = 4'b1111;
                misaligned = (st_offset_i != 2'b00);
            end
            default: st_be_o = 4'b0000;
        endcase
    end

    assign st_illegal_o = f3_bad || misaligned;

    // Replicate the store data so whichever lanes are enabled carry it.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign st_wdata_o[8*gi +: 8] = (st_size == 2'b00) ? st_wdata_i[7:0] :
                                       (st_size == 2'b01) ? st_wdata_i[8*(gi%2) +: 8] :
                                                            st_wdata_i[8*gi +: 8];
    end

    // Bring the addressed byte/half down to bit 0 before extending.
    assign ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};

    always_comb begin
        ld_data_o = 32'h0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_W:    ld_data_o = ld_rdata_i;
            F3_BU:   ld_data_o = {24'h0, ld_shifted[7:0]};
            F3_HU:   ld_data_o = {16'h0, ld_shifted[15:0]};
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage behind the PE controller.
// Takes a held load/store request, runs one req/gnt/rvalid transaction on
// the data bus and returns a one-cycle mem_ack with the extended load value
// (mem_Message) and an error flag (misaligned, illegal, or bus timeout).
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   mau_io  : mem_access_unit_if.master (controller + bus signals)
// Parameter TIMEOUT_CYCLES (1..255): cycles allowed in REQ+RESP.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.master  mau_io
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic        ack_q;
    logic [31:0] msg_q;
    logic        err_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        st_illegal;
    logic [31:0] ld_data;
    logic        illegal_d;
    logic        any_req;
    logic        timeout_hit;

    lsu_align u_align (
        .st_offset_i  (mau_io.mem_address[1:0]),
        .st_funct3_i  (mau_io.funct3),
        .st_we_i      (mau_io.mem_write),
        .st_wdata_i   (mau_io.mem_wdata),
        .st_be_o      (be_d),
        .st_wdata_o   (wdata_d),
        .st_illegal_o (st_illegal),
        .ld_offset_i  (off_q),
        .ld_funct3_i  (f3_q),
        .ld_rdata_i   (mau_io.bus_rdata),
        .ld_data_o    (ld_data)
    );

    assign any_req     = mau_io.mem_read || mau_io.mem_write;
    assign illegal_d   = (mau_io.mem_read && mau_io.mem_write) || st_illegal;
    // cnt_q counts REQ+RESP cycles already spent; this cycle is the last allowed.
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'h0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            ack_q       <= 1'b0;
            msg_q       <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        if (illegal_d) begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            msg_q   <= 32'h0;
                            state_q <= ST_ACK;
                        end else begin
                            off_q       <= mau_io.mem_address[1:0];
                            f3_q        <= mau_io.funct3;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mau_io.mem_write;
                            bus_addr_q  <= {mau_io.mem_address[31:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            cnt_q       <= 8'h0;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant arriving in the final allowed cycle cannot finish
                    // in time, so the timeout takes precedence here.
                    if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b1;
                        msg_q     <= 32'h0;
                        state_q   <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (mau_io.bus_gnt) begin
                            bus_req_q <= 1'b0;
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // A response in the final allowed cycle still completes.
                    if (mau_io.bus_rvalid) begin
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                        msg_q   <= bus_we_q ? 32'h0 : ld_data;
                        state_q <= ST_ACK;
                    end else if (timeout_hit) begin
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        msg_q   <= 32'h0;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    // The controller keeps its request up until it sees the ack;
                    // wait for it to drop so the same request is not reissued.
                    if (!any_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mau_io.mem_ack     = ack_q;
    assign mau_io.mem_Message = msg_q;
    assign mau_io.mem_err     = err_q;
    assign mau_io.bus_req     = bus_req_q;
    assign mau_io.bus_we      = bus_we_q;
    assign mau_io.bus_addr    = bus_addr_q;
    assign mau_io.bus_be      = bus_be_q;
    assign mau_io.bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected acks and
// bus requests into queues; monitors on the falling edge pop and compare.
module tb_mem_access_unit;

    localparam int T = 8;
    localparam int NEVER = 1000;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if mau ();

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mau_io (mau.master)
    );

    resp_t exp_q[$];
    busx_t bus_q[$];
    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (txn %0d, t=%0t)", name, act, exp, txn_no, $time);
        end
    endtask

    // Reference model: derived from size/offset arithmetic.
    task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rdata,
                         output logic legal, output busx_t bx, output logic [31:0] ld);
        int size;
        bit sgn;
        int off;
        int bm;
        logic [63:0] m;
        logic [63:0] v;
        off = int'(addr[1:0]);
        size = 0;
        sgn = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: size = 0;
        endcase
        legal = (rd != wr) && (size != 0) && !(wr && f3 >= 3'd4) && ((off % (size == 0 ? 1 : size)) == 0);
        bm = ((1 << size) - 1) << off;
        bx.we = wr;
        bx.addr = addr - 32'(off);
        bx.be = bm[3:0];
        if (size == 1)      bx.wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) bx.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else                bx.wdata = wd;
        m = (64'd1 << (8 * size)) - 64'd1;
        v = ({32'd0, rdata} >> (8 * off)) & m;
        if (sgn && size != 0 && v[8*size-1]) v = v | ~m;
        ld = v[31:0];
    endtask

    // Scoreboard monitors.
    resp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mau.mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_data", mau.mem_Message, mon_e.data);
                    check("ack_err", 32'(mau.mem_err), 32'(mon_e.err));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mau.bus_req) begin
            if (bus_q.size() == 0) begin
                check("unexpected_bus_req", 32'd1, 32'd0);
            end else begin
                check("bus_we", 32'(mau.bus_we), 32'(bus_q[0].we));
                check("bus_addr", mau.bus_addr, bus_q[0].addr);
                check("bus_be", 32'(mau.bus_be), 32'(bus_q[0].be));
                check("bus_wdata", mau.bus_wdata, bus_q[0].wdata);
                if (mau.bus_gnt) void'(bus_q.pop_front());
            end
        end
    end

    // One transaction: called at posedge+1 with the DUT idle.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input int g, input int r, input logic [31:0] rdata,
                          input int hold, input bit late_rv);
        logic legal;
        busx_t bx;
        logic [31:0] ld;
        resp_t e;
        bit ok;
        int exp_lat;
        int k;
        int phase;
        int cnt;
        bit got;
        txn_no++;
        model(rd, wr, addr, f3, wd, rdata, legal, bx, ld);
        ok = (g + r + 2) <= T;
        e.data = (legal && ok && !wr) ? ld : 32'h0;
        e.err = !(legal && ok);
        exp_lat = !legal ? 1 : (ok ? g + r + 3 : T + 1);
        exp_q.push_back(e);
        if (legal) bus_q.push_back(bx);
        $display("txn %0d: rd=%0b wr=%0b addr=%h f3=%0d wd=%h g=%0d r=%0d rdata=%h -> data=%h err=%0b lat=%0d",
                 txn_no, rd, wr, addr, f3, wd, g, r, rdata, e.data, e.err, exp_lat);
        mau.mem_read = rd;
        mau.mem_write = wr;
        mau.mem_address = addr;
        mau.funct3 = f3;
        mau.mem_wdata = wd;
        k = 0;
        phase = 0;
        cnt = 0;
        got = 0;
        while (k < 40 && !got) begin
            @(posedge clk);
            #1;
            k++;
            mau.bus_gnt = 1'b0;
            mau.bus_rvalid = 1'b0;
            mau.bus_rdata = $urandom;
            if (mau.mem_ack) begin
                got = 1;
            end else if (phase == 0) begin
                if (mau.bus_req) begin
                    if (cnt == g) begin
                        mau.bus_gnt = 1'b1;
                        phase = 1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else if (phase == 1) begin
                if (cnt == r) begin
                    mau.bus_rvalid = 1'b1;
                    mau.bus_rdata = rdata;
                    phase = 2;
                end else begin
                    cnt++;
                end
            end
        end
        if (!got) check("ack_wait_bound", 32'(k), 32'(exp_lat));
        else      check("latency", 32'(k), 32'(exp_lat));
        if (legal && g >= T - 1 && bus_q.size() > 0) void'(bus_q.pop_front());
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            mau.bus_gnt = 1'b0;
            mau.bus_rvalid = (late_rv && h == 0);
            mau.bus_rdata = $urandom;
        end
        mau.bus_rvalid = 1'b0;
        if (hold > 0) begin
            check("held_msg", mau.mem_Message, e.data);
            check("held_err", 32'(mau.mem_err), 32'(e.err));
        end
        mau.mem_read = 1'b0;
        mau.mem_write = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(mau.mem_ack), 32'd0);
        check({tag, "_msg"}, mau.mem_Message, 32'd0);
        check({tag, "_err"}, 32'(mau.mem_err), 32'd0);
        check({tag, "_req"}, 32'(mau.bus_req), 32'd0);
        check({tag, "_we"}, 32'(mau.bus_we), 32'd0);
        check({tag, "_addr"}, mau.bus_addr, 32'd0);
        check({tag, "_be"}, 32'(mau.bus_be), 32'd0);
        check({tag, "_wdata"}, mau.bus_wdata, 32'd0);
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        logic rd;
        logic wr;
        int sel;
        int g;
        logic [2:0] f3;
        busx_t bx;
        logic legal;
        logic [31:0] ld;

        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
        mau.mem_read = 1'b0;
        mau.mem_write = 1'b0;
        mau.mem_address = 32'h0;
        mau.funct3 = 3'h0;
        mau.mem_wdata = 32'h0;
        mau.bus_gnt = 1'b0;
        mau.bus_rvalid = 1'b0;
        mau.bus_rdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        do_txn(1, 0, 32'h103, 3'd0, 32'h0, 0, 0, 32'h80FF_1234, 0, 0);     // LB
        do_txn(1, 0, 32'h102, 3'd5, 32'h0, 0, 0, 32'hBEEF_0000, 0, 0);     // LHU
        do_txn(0, 1, 32'h101, 3'd0, 32'h0000_00A5, 0, 0, 32'h0, 0, 0);     // SB
        do_txn(1, 0, 32'h002, 3'd2, 32'h0, 0, 0, 32'h0, 0, 0);             // misaligned LW
        do_txn(1, 0, 32'h040, 3'd2, 32'h0, NEVER, 0, 32'h0, 2, 1);         // timeout + late rvalid
        do_txn(1, 0, 32'h205, 3'd0, 32'h0, 1, 1, 32'h1234_7F00, 5, 0);     // held 5 cycles
        do_txn(1, 0, 32'h300, 3'd2, 32'h0, 2, 4, 32'hCAFE_F00D, 0, 0);     // exactly at the limit
        do_txn(1, 0, 32'h300, 3'd2, 32'h0, 2, 5, 32'hCAFE_F00D, 0, 0);     // one past the limit

        // Reset in RESP: no ack may follow.
        txn_no++;
        $display("txn %0d: reset during RESP", txn_no);
        model(1, 0, 32'h200, 3'd2, 32'h0, 32'h0, legal, bx, ld);
        bus_q.push_back(bx);
        mau.mem_read = 1'b1;
        mau.mem_address = 32'h200;
        mau.funct3 = 3'd2;
        @(posedge clk);
        #1;
        mau.bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        mau.bus_gnt = 1'b0;
        rst_n = 1'b0;
        mau.mem_read = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mau.bus_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mau.bus_rvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_no_ack", 32'(mau.mem_ack), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            rd = (sel == 0) ? 1'b1 : sel[0];
            wr = (sel == 0) ? 1'b1 : ~sel[0];
            f3 = ($urandom_range(0, 9) < 7) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            g = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 5);
            sel = $urandom_range(0, 3);
            do_txn(rd, wr, $urandom, f3, $urandom, g, $urandom_range(0, 6), $urandom,
                   sel, (sel > 0) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
